seq_mult_unit: RTL and testbench

- Parametrised iterative radix-2 shift-add multiplier for neuron datapaths.
- Generalises the fixed 2-bit combinational multiplier to WIDTH-bit operands.
- Adds signed/unsigned mode, a valid/ready handshake on both sides, and a WIDTH-cycle fixed latency.
- Sits between the weight/input fetch logic and the neuron accumulator; trades area for throughput.

---
 rtl/ann_pkg.sv | 14 +
 rtl/mult_sign_fix.sv | 17 +
 rtl/seq_mult_unit.sv | 124 ++++++++++++
 tb/tb_seq_mult_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared types and helpers for the neuron datapath arithmetic blocks.
package ann_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/mult_sign_fix.sv
// Combinational conditional two's-complement negate, used for |x| at the
// operand inputs and for restoring the product sign at the output.
module mult_sign_fix #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    // Negating 100..0 yields 100..0, which is the correct magnitude when the
    // result is read as unsigned.
    always_comb begin
        y = neg ? (~x + W'(1)) : x;
    end

endmodule

// File: rtl/seq_mult_unit.sv
// Iterative radix-2 shift-add multiplier with signed/unsigned mode, valid/ready
// handshakes on both sides and a fixed WIDTH-cycle latency.
module seq_mult_unit
    import ann_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int PW = prod_width(WIDTH);
    localparam int CW = $clog2(WIDTH) + 1;

    mult_state_e     state_q, state_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   p_q, p_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [PW-1:0]   addend, acc_sum, acc_signed;

    mult_sign_fix #(.W(WIDTH)) u_abs_a (
        .x   (a),
        .neg (is_signed & a[WIDTH-1]),
        .y   (abs_a)
    );

    mult_sign_fix #(.W(WIDTH)) u_abs_b (
        .x   (b),
        .neg (is_signed & b[WIDTH-1]),
        .y   (abs_b)
    );

    always_comb begin
        addend  = mag_b_q[0] ? (PW'(mag_a_q) << cnt_q) : '0;
        acc_sum = acc_q + addend;
    end

    // The final partial product is folded in before the sign is applied, so p
    // is loaded directly from this cycle's sum.
    mult_sign_fix #(.W(PW)) u_neg_p (
        .x   (acc_sum),
        .neg (neg_q),
        .y   (acc_signed)
    );

    always_comb begin
        state_d = state_q;
        mag_a_d = mag_a_q;
        mag_b_d = mag_b_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_a_d = abs_a;
                    mag_b_d = abs_b;
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d   = acc_sum;
                mag_b_d = mag_b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    p_d     = acc_signed;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_a_q <= '0;
            mag_b_q <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        p         = p_q;
    end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit: an 8-bit instance for the functional and
// handshake scenarios and a 2-bit instance swept exhaustively back to back.
module tb_seq_mult_unit;

    logic clk;
    logic rst_n;

    logic        in_valid8, in_ready8, is_signed8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        in_valid2, in_ready2, is_signed2, out_valid2, out_ready2, busy2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;

    int checks;
    int errors;

    seq_mult_unit #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .is_signed (is_signed8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .p         (p8),
        .busy      (busy8)
    );

    seq_mult_unit #(.WIDTH(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .is_signed (is_signed2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .p         (p2),
        .busy      (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one 8-bit operation at a falling edge, then count rising edges
    // until out_valid is seen. Leaves the unit in DONE; the caller decides
    // when the product is consumed.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                          output logic [15:0] pv, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready8 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        a8 = av; b8 = bv; is_signed8 = sv; in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        lat = 0;
        pv  = 'x;
        while (lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid8) break;
        end
        if (!out_valid8) begin
            checks++; errors++;
            $display("FAIL issue8_timeout: out_valid=%b after %0d edges, required 1", out_valid8, lat);
        end
        pv = p8;
    endtask

    task automatic consume8();
        out_ready8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready8); end
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid8); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy8); end
        checks++; if (p8 !== 16'h0000) begin errors++; $display("FAIL reset_p: got %h want 0000", p8); end
        checks++; if (p2 !== 4'h0 || in_ready2 !== 1'b1) begin errors++; $display("FAIL reset_w2: p=%h in_ready=%b want 0/1", p2, in_ready2); end
    endtask

    task automatic test_unsigned();
        logic [15:0] pv;
        int lat;
        out_ready8 = 1'b1;
        issue8(8'd3, 8'd5, 1'b0, pv, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL u_3x5_latency: got %0d want 8", lat); end
        checks++; if (pv !== 16'h000F) begin errors++; $display("FAIL u_3x5_p: got %h want 000f", pv); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin errors++; $display("FAIL u_3x5_release: in_ready=%b out_valid=%b want 1/0", in_ready8, out_valid8); end
        issue8(8'd255, 8'd255, 1'b0, pv, lat);
        checks++; if (pv !== 16'hFE01) begin errors++; $display("FAIL u_255x255_p: got %h want fe01", pv); end
        consume8();
    endtask

    task automatic test_signed();
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic [15:0] vp [4];
        logic [15:0] pv;
        int lat;
        va[0] = 8'hFD; vb[0] = 8'h05; vp[0] = 16'hFFF1;
        va[1] = 8'h80; vb[1] = 8'h80; vp[1] = 16'h4000;
        va[2] = 8'h80; vb[2] = 8'h7F; vp[2] = 16'hC080;
        va[3] = 8'h00; vb[3] = 8'hF9; vp[3] = 16'h0000;
        out_ready8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue8(va[i], vb[i], 1'b1, pv, lat);
            checks++;
            if (pv !== vp[i] || lat !== 8) begin
                errors++;
                $display("FAIL s_vec%0d: a=%h b=%h got p=%h lat=%0d want p=%h lat=8", i, va[i], vb[i], pv, lat, vp[i]);
            end
            consume8();
        end
        // Unsigned interpretation of the same bits must differ: 0xFD*5 = 0x04F1.
        issue8(8'hFD, 8'h05, 1'b0, pv, lat);
        checks++; if (pv !== 16'h04F1) begin errors++; $display("FAIL u_253x5_p: got %h want 04f1", pv); end
        consume8();
    endtask

    task automatic test_backpressure();
        int guard;
        int lat;
        out_ready8 = 1'b0;
        @(negedge clk);
        a8 = 8'd12; b8 = 8'd10; is_signed8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd1; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d want 8", lat); end
        in_valid8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (p8 !== 16'h0078 || out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: p=%h out_valid=%b in_ready=%b want 0078/1/0", i, p8, out_valid8, in_ready8);
            end
            @(negedge clk);
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || p8 !== 16'h0078) begin errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b p=%h want 0/1/0078", out_valid8, in_ready8, p8); end
        guard = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy8) guard++;
        end
        checks++; if (guard !== 0) begin errors++; $display("FAIL bp_no_replay: busy cycles=%0d want 0", guard); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] pv;
        int lat;
        out_ready8 = 1'b1;
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd100; is_signed8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (out_valid8 !== 1'b0 || p8 !== 16'h0000 || in_ready8 !== 1'b1) begin errors++; $display("FAIL rst_mid: out_valid=%b p=%h in_ready=%b want 0/0000/1", out_valid8, p8, in_ready8); end
        @(negedge clk);
        rst_n = 1'b1;
        issue8(8'd7, 8'd6, 1'b0, pv, lat);
        checks++; if (pv !== 16'd42 || lat !== 8) begin errors++; $display("FAIL rst_then_7x6: p=%h lat=%0d want 002a/8", pv, lat); end
        consume8();
    endtask

    task automatic test_back_to_back_w2();
        logic [3:0] exp_p;
        logic [3:0] got_p;
        logic [1:0] ua, ub;
        int low_cycles;
        int guard;
        out_ready2 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 32; k++) begin
            ua = k[1:0];
            ub = k[3:2];
            if (k >= 16)
                exp_p = 4'($signed({{2{ua[1]}}, ua}) * $signed({{2{ub[1]}}, ub}));
            else
                exp_p = 4'({2'b00, ua} * {2'b00, ub});
            guard = 0;
            while (!in_ready2 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            a2 = ua; b2 = ub; is_signed2 = (k >= 16); in_valid2 = 1'b1;
            @(negedge clk);
            in_valid2 = 1'b0;
            low_cycles = 0;
            got_p = 'x;
            while (!in_ready2 && low_cycles < 20) begin
                if (out_valid2) got_p = p2;
                low_cycles++;
                @(negedge clk);
            end
            checks++;
            if (got_p !== exp_p || low_cycles !== 3) begin
                errors++;
                $display("FAIL w2_vec%0d: signed=%0d a=%b b=%b got p=%b busy_cycles=%0d want p=%b busy_cycles=3",
                         k, (k >= 16), ua, ub, got_p, low_cycles, exp_p);
            end
            if (k == 15) begin
                checks++; if (got_p !== 4'b1001) begin errors++; $display("FAIL w2_u3x3: got %b want 1001", got_p); end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; is_signed8 = 1'b0; out_ready8 = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; is_signed2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back_w2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
